// File: rtl/bcd_mod_counter_pkg.sv
// Shared definitions for the clock datapath field counters: BCD digit type
// and a helper turning a decimal constant into a {ten, unit} BCD pair.
package clock_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX_DIGIT = 4'd9;

  typedef struct packed {
    bcd_t ten;
    bcd_t unit;
  } bcd2_t;

  function automatic bcd2_t dec_to_bcd2(input int unsigned value);
    bcd2_t pair_s;
    pair_s.ten  = bcd_t'((value / 32'd10) % 32'd10);
    pair_s.unit = bcd_t'(value % 32'd10);
    return pair_s;
  endfunction

endpackage

// File: rtl/bcd_mod_counter_bcd2_step.sv
// Combinational two-digit BCD step: increment/decrement with digit roll and
// compares against the effective limit and the minimum value.
module bcd2_step
  import clock_pkg::*;
(
  input  logic [3:0] v_ten,
  input  logic [3:0] v_unit,
  input  logic [3:0] lim_ten,
  input  logic [3:0] lim_unit,
  input  logic [3:0] min_ten,
  input  logic [3:0] min_unit,
  output logic [3:0] inc_ten,
  output logic [3:0] inc_unit,
  output logic [3:0] dec_ten,
  output logic [3:0] dec_unit,
  output logic       ge_lim,
  output logic       gt_lim,
  output logic       eq_min
);

  logic [7:0] v_s;
  logic [7:0] lim_s;
  logic [7:0] min_s;

  // Valid BCD pairs order the same way as their packed 8-bit encoding.
  assign v_s   = {v_ten, v_unit};
  assign lim_s = {lim_ten, lim_unit};
  assign min_s = {min_ten, min_unit};

  assign ge_lim = (v_s >= lim_s);
  assign gt_lim = (v_s > lim_s);
  assign eq_min = (v_s == min_s);

  // Increment with unit roll x9 -> (x+1)0.
  always_comb begin
    inc_ten  = v_ten;
    inc_unit = v_unit + 4'd1;
    if (v_unit >= BCD_MAX_DIGIT) begin
      inc_ten  = v_ten + 4'd1;
      inc_unit = 4'd0;
    end else begin
      inc_ten  = v_ten;
    end
  end

  // Decrement with unit roll x0 -> (x-1)9.
  always_comb begin
    dec_ten  = v_ten;
    dec_unit = v_unit - 4'd1;
    if (v_unit == 4'd0) begin
      dec_ten  = v_ten - 4'd1;
      dec_unit = BCD_MAX_DIGIT;
    end else begin
      dec_ten  = v_ten;
    end
  end

endmodule

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter for time/date fields: configurable min/max,
// optional runtime upper limit, validated load and carry/borrow chaining.
module bcd_mod_counter
  import clock_pkg::*;
#(
  parameter int unsigned MAX_VALUE     = 32'd59,
  parameter int unsigned MIN_VALUE     = 32'd0,
  parameter int unsigned USE_DYN_LIMIT = 32'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up,
  input  logic       down,
  input  logic       load,
  input  logic [3:0] load_ten,
  input  logic [3:0] load_unit,
  input  logic [3:0] lim_ten,
  input  logic [3:0] lim_unit,
  output logic [3:0] count_ten,
  output logic [3:0] count_unit,
  output logic       carry_o,
  output logic       borrow_o,
  output logic       load_err
);

  localparam logic [7:0] MAX_BCD = dec_to_bcd2(MAX_VALUE);
  localparam logic [7:0] MIN_BCD = dec_to_bcd2(MIN_VALUE);

  if ((MIN_VALUE >= MAX_VALUE) || (MAX_VALUE > 32'd99) || (MIN_VALUE > 32'd1)) begin : g_param_check
    $error("bcd_mod_counter: need MIN_VALUE in {0,1} and MIN_VALUE < MAX_VALUE <= 99");
  end

  logic [7:0] value_r;
  logic       carry_r;
  logic       borrow_r;
  logic       load_err_r;

  logic [7:0] value_nxt_s;
  logic       carry_nxt_s;
  logic       borrow_nxt_s;
  logic       load_err_nxt_s;

  logic [7:0] lim_s;
  logic [7:0] load_s;
  logic       load_ok_s;
  logic [3:0] inc_ten_s;
  logic [3:0] inc_unit_s;
  logic [3:0] dec_ten_s;
  logic [3:0] dec_unit_s;
  logic       ge_lim_s;
  logic       gt_lim_s;
  logic       eq_min_s;

  assign lim_s  = (USE_DYN_LIMIT != 32'd0) ? {lim_ten, lim_unit} : MAX_BCD;
  assign load_s = {load_ten, load_unit};

  // Digit validity must hold before the packed compare means anything.
  assign load_ok_s = (load_ten <= BCD_MAX_DIGIT) && (load_unit <= BCD_MAX_DIGIT) &&
                     (load_s >= MIN_BCD) && (load_s <= lim_s);

  bcd2_step u_step (
    .v_ten    (value_r[7:4]),
    .v_unit   (value_r[3:0]),
    .lim_ten  (lim_s[7:4]),
    .lim_unit (lim_s[3:0]),
    .min_ten  (MIN_BCD[7:4]),
    .min_unit (MIN_BCD[3:0]),
    .inc_ten  (inc_ten_s),
    .inc_unit (inc_unit_s),
    .dec_ten  (dec_ten_s),
    .dec_unit (dec_unit_s),
    .ge_lim   (ge_lim_s),
    .gt_lim   (gt_lim_s),
    .eq_min   (eq_min_s)
  );

  // Next value and pulses: load beats en; en only acts with exactly one direction.
  always_comb begin
    value_nxt_s    = value_r;
    carry_nxt_s    = 1'b0;
    borrow_nxt_s   = 1'b0;
    load_err_nxt_s = 1'b0;
    if (load) begin
      if (load_ok_s) begin
        value_nxt_s = load_s;
      end else begin
        load_err_nxt_s = 1'b1;
      end
    end else if (en && (up != down)) begin
      if (up) begin
        if (ge_lim_s) begin
          value_nxt_s = MIN_BCD;
          carry_nxt_s = 1'b1;
        end else begin
          value_nxt_s = {inc_ten_s, inc_unit_s};
        end
      end else begin
        // A shrunken limit clamps silently rather than signalling a wrap.
        if (gt_lim_s) begin
          value_nxt_s = lim_s;
        end else if (eq_min_s) begin
          value_nxt_s  = lim_s;
          borrow_nxt_s = 1'b1;
        end else begin
          value_nxt_s = {dec_ten_s, dec_unit_s};
        end
      end
    end else begin
      value_nxt_s = value_r;
    end
  end

  // State and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_r    <= MIN_BCD;
      carry_r    <= 1'b0;
      borrow_r   <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      value_r    <= value_nxt_s;
      carry_r    <= carry_nxt_s;
      borrow_r   <= borrow_nxt_s;
      load_err_r <= load_err_nxt_s;
    end
  end

  assign count_ten  = value_r[7:4];
  assign count_unit = value_r[3:0];
  assign carry_o    = carry_r;
  assign borrow_o   = borrow_r;
  assign load_err   = load_err_r;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Scoreboard bench for bcd_mod_counter: six instances with different
// parameters (the last two chained), directed vectors, negedge monitor.
module tb_bcd_mod_counter;

  localparam int N = 6;
  localparam int unsigned MAXV [N] = '{32'd59, 32'd23, 32'd12, 32'd31, 32'd59, 32'd23};
  localparam int unsigned MINV [N] = '{32'd0,  32'd0,  32'd1,  32'd1,  32'd0,  32'd0};
  localparam int unsigned DYNV [N] = '{32'd0,  32'd0,  32'd0,  32'd1,  32'd0,  32'd0};

  logic clk = 1'b0;
  logic rst_n;
  logic       en [N];
  logic       up [N];
  logic       down [N];
  logic       load [N];
  logic [3:0] load_ten [N];
  logic [3:0] load_unit [N];
  logic [3:0] lim_ten [N];
  logic [3:0] lim_unit [N];
  logic [3:0] count_ten [N];
  logic [3:0] count_unit [N];
  logic       carry [N];
  logic       borrow [N];
  logic       load_err [N];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    int         id;
    int         due;
    logic [3:0] ten;
    logic [3:0] unit;
    logic       c;
    logic       b;
    logic       e;
    string      name;
  } exp_t;

  exp_t sb [$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < N; g++) begin : g_dut
    bcd_mod_counter #(
      .MAX_VALUE     (MAXV[g]),
      .MIN_VALUE     (MINV[g]),
      .USE_DYN_LIMIT (DYNV[g])
    ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         ((g == 5) ? carry[4] : en[g]),
      .up         (up[g]),
      .down       (down[g]),
      .load       (load[g]),
      .load_ten   (load_ten[g]),
      .load_unit  (load_unit[g]),
      .lim_ten    (lim_ten[g]),
      .lim_unit   (lim_unit[g]),
      .count_ten  (count_ten[g]),
      .count_unit (count_unit[g]),
      .carry_o    (carry[g]),
      .borrow_o   (borrow[g]),
      .load_err   (load_err[g])
    );
  end

  task automatic check_now(input int id, input string nm, input logic [3:0] et, input logic [3:0] eu,
                           input logic ec, input logic eb, input logic ee);
    checks++;
    if (count_ten[id] !== et || count_unit[id] !== eu || carry[id] !== ec ||
        borrow[id] !== eb || load_err[id] !== ee) begin
      failures++;
      $display("FAIL %s dut%0d: got %0h%0h carry=%b borrow=%b err=%b, want %0h%0h carry=%b borrow=%b err=%b",
               nm, id, count_ten[id], count_unit[id], carry[id], borrow[id], load_err[id],
               et, eu, ec, eb, ee);
    end
  endtask

  task automatic expect_next(input int id, input string nm, input logic [3:0] t, input logic [3:0] u,
                             input logic c, input logic b, input logic e);
    exp_t x;
    x.id = id; x.due = cyc + 1; x.ten = t; x.unit = u;
    x.c = c; x.b = b; x.e = e; x.name = nm;
    sb.push_back(x);
  endtask

  // Monitor: compare every entry whose cycle has arrived, away from the active edge.
  always @(negedge clk) begin
    exp_t x;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      x = sb.pop_front();
      check_now(x.id, x.name, x.ten, x.unit, x.c, x.b, x.e);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      en[i]   = 1'b0;
      load[i] = 1'b0;
    end
  endtask

  task automatic do_load(input int id, input logic [3:0] t, input logic [3:0] u);
    load[id] = 1'b1; load_ten[id] = t; load_unit[id] = u;
  endtask

  task automatic tick(input int id, input logic u, input logic d);
    en[id] = 1'b1; up[id] = u; down[id] = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      en[i] = 1'b0; up[i] = 1'b0; down[i] = 1'b0; load[i] = 1'b0;
      load_ten[i] = 4'd0; load_unit[i] = 4'd0; lim_ten[i] = 4'd0; lim_unit[i] = 4'd0;
    end
    lim_ten[3] = 4'd3; lim_unit[3] = 4'd1;
    #12;
    check_now(0, "rst_m59", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    check_now(1, "rst_m23", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    check_now(2, "rst_min1", 4'd0, 4'd1, 1'b0, 1'b0, 1'b0);
    check_now(3, "rst_dyn", 4'd0, 4'd1, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();

    // 60 back-to-back up ticks on the 0..59 counter
    for (int i = 1; i <= 60; i++) begin
      tick(0, 1'b1, 1'b0);
      expect_next(0, "up59", 4'((i % 60) / 10), 4'((i % 60) % 10), (i == 60), 1'b0, 1'b0);
      step();
    end

    // 0..23: down from max, down-wrap with borrow
    do_load(1, 4'd2, 4'd3);  expect_next(1, "m23_load23", 4'd2, 4'd3, 1'b0, 1'b0, 1'b0); step();
    tick(1, 1'b0, 1'b1);     expect_next(1, "m23_down", 4'd2, 4'd2, 1'b0, 1'b0, 1'b0); step();
    do_load(1, 4'd0, 4'd0);  expect_next(1, "m23_load00", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0); step();
    tick(1, 1'b0, 1'b1);     expect_next(1, "m23_borrow", 4'd2, 4'd3, 1'b0, 1'b1, 1'b0); step();
    expect_next(1, "m23_idle", 4'd2, 4'd3, 1'b0, 1'b0, 1'b0); step();

    // 1..12: wrap to 01 with carry, reject load below minimum
    do_load(2, 4'd1, 4'd2);  expect_next(2, "m12_load12", 4'd1, 4'd2, 1'b0, 1'b0, 1'b0); step();
    tick(2, 1'b1, 1'b0);     expect_next(2, "m12_carry", 4'd0, 4'd1, 1'b1, 1'b0, 1'b0); step();
    do_load(2, 4'd0, 4'd0);  expect_next(2, "m12_rej00", 4'd0, 4'd1, 1'b0, 1'b0, 1'b1); step();
    expect_next(2, "m12_idle", 4'd0, 4'd1, 1'b0, 1'b0, 1'b0); step();

    // Runtime limit: shrink below value, wrap up, clamp down, borrow to limit
    do_load(3, 4'd3, 4'd1);  expect_next(3, "dyn_load31", 4'd3, 4'd1, 1'b0, 1'b0, 1'b0); step();
    lim_ten[3] = 4'd2; lim_unit[3] = 4'd8;
    expect_next(3, "dyn_shrink_hold", 4'd3, 4'd1, 1'b0, 1'b0, 1'b0); step();
    tick(3, 1'b1, 1'b0);     expect_next(3, "dyn_up_wrap", 4'd0, 4'd1, 1'b1, 1'b0, 1'b0); step();
    lim_ten[3] = 4'd3; lim_unit[3] = 4'd1;
    do_load(3, 4'd3, 4'd0);  expect_next(3, "dyn_load30", 4'd3, 4'd0, 1'b0, 1'b0, 1'b0); step();
    lim_ten[3] = 4'd2; lim_unit[3] = 4'd8;
    tick(3, 1'b0, 1'b1);     expect_next(3, "dyn_clamp", 4'd2, 4'd8, 1'b0, 1'b0, 1'b0); step();
    tick(3, 1'b0, 1'b1);     expect_next(3, "dyn_down", 4'd2, 4'd7, 1'b0, 1'b0, 1'b0); step();
    do_load(3, 4'd0, 4'd1);  expect_next(3, "dyn_load01", 4'd0, 4'd1, 1'b0, 1'b0, 1'b0); step();
    tick(3, 1'b0, 1'b1);     expect_next(3, "dyn_borrow", 4'd2, 4'd8, 1'b0, 1'b1, 1'b0); step();

    // Invalid loads drop en; ambiguous direction holds
    do_load(0, 4'd5, 4'hA); tick(0, 1'b1, 1'b0);
    expect_next(0, "load5A_rej", 4'd0, 4'd0, 1'b0, 1'b0, 1'b1); step();
    tick(0, 1'b1, 1'b1);     expect_next(0, "updown_hold", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0); step();
    tick(0, 1'b0, 1'b0);     expect_next(0, "nodir_hold", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0); step();
    do_load(0, 4'd6, 4'd0);  expect_next(0, "load60_rej", 4'd0, 4'd0, 1'b0, 1'b0, 1'b1); step();
    do_load(0, 4'd0, 4'd9);  expect_next(0, "load09", 4'd0, 4'd9, 1'b0, 1'b0, 1'b0); step();
    tick(0, 1'b1, 1'b0);     expect_next(0, "roll_up", 4'd1, 4'd0, 1'b0, 1'b0, 1'b0); step();
    tick(0, 1'b0, 1'b1);     expect_next(0, "roll_down", 4'd0, 4'd9, 1'b0, 1'b0, 1'b0); step();

    // Chain 23:59 -> 00:00
    up[4] = 1'b1; down[4] = 1'b0; up[5] = 1'b1; down[5] = 1'b0;
    do_load(4, 4'd5, 4'd9); do_load(5, 4'd2, 4'd3);
    expect_next(4, "chain_ld_lo", 4'd5, 4'd9, 1'b0, 1'b0, 1'b0);
    expect_next(5, "chain_ld_hi", 4'd2, 4'd3, 1'b0, 1'b0, 1'b0); step();
    tick(4, 1'b1, 1'b0);
    expect_next(4, "chain_c1_lo", 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    expect_next(5, "chain_c1_hi", 4'd2, 4'd3, 1'b0, 1'b0, 1'b0); step();
    expect_next(4, "chain_c2_lo", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    expect_next(5, "chain_c2_hi", 4'd0, 4'd0, 1'b1, 1'b0, 1'b0); step();
    expect_next(5, "chain_c3_hi", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0); step();

    // Async reset while the carry is travelling down the chain
    do_load(4, 4'd5, 4'd9); do_load(5, 4'd2, 4'd3);
    expect_next(4, "chain2_ld_lo", 4'd5, 4'd9, 1'b0, 1'b0, 1'b0);
    expect_next(5, "chain2_ld_hi", 4'd2, 4'd3, 1'b0, 1'b0, 1'b0); step();
    tick(4, 1'b1, 1'b0); step();
    check_now(4, "chain2_wrap_lo", 4'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    check_now(5, "chain2_wrap_hi", 4'd2, 4'd3, 1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check_now(4, "async_rst_lo", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    check_now(5, "async_rst_hi", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    step();

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
